rr_arb_mux: RTL and testbench

- Parametrised, registered N-channel arbitrating multiplexer. It is the sequential successor to the datapath 2:1 selects.
- Selects one of NUM_CH valid/ready source channels per cycle, using round-robin or fixed-priority arbitration.
- Captures the winner's data into an output register with a valid/ready handshake.
- Used wherever several producers share one datapath port: writeback result select, load/store request merge, debug port merge.

---
 rtl/rr_arb_mux.sv | 149 ++++++++++++++
 tb/tb_rr_arb_mux.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: registered N-channel arbitrating multiplexer.
//
// Picks one of NUM_CH valid/ready source channels per cycle. MODE=0 is
// round-robin: the search starts at a rotating pointer. MODE=1 is fixed
// priority: the lowest index wins. The winner's data is captured into an
// output register that is offered downstream with a valid/ready handshake.
//
// Ports:
//   clk        rising-edge system clock
//   rst        asynchronous, active-high reset
//   in_valid   per-channel request valid               [NUM_CH]
//   in_data    packed channel data, ch i at [i*WIDTH +: WIDTH]
//   in_ready   per-channel accept, one-hot or zero     [NUM_CH]
//   out_valid  output register holds a transfer
//   out_data   registered data of the granted channel  [WIDTH]
//   out_ch     index of the channel that produced out_data [CH_W]
//   out_ready  downstream accepts the output this cycle
module rr_arb_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int MODE   = 0,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    input  logic                    out_ready
);

    logic [CH_W-1:0]   ptr_q;
    logic [CH_W-1:0]   ptr_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [WIDTH-1:0]  out_data_q;
    logic [WIDTH-1:0]  out_data_d;
    logic [CH_W-1:0]   out_ch_q;
    logic [CH_W-1:0]   out_ch_d;

    logic              load_s;
    logic              found_s;
    logic [CH_W-1:0]   winner_s;
    logic [WIDTH-1:0]  win_data_s;
    logic [NUM_CH-1:0] in_ready_s;

    // The output register may take a new word when it is empty or being drained.
    assign load_s = !out_valid_q || out_ready;

    // Arbitration: each channel gets a rank equal to its distance from the
    // search start (modulo NUM_CH); the valid channel with the lowest rank wins.
    always_comb begin
        int start;
        int rank;
        int best_rank;
        found_s   = 1'b0;
        winner_s  = '0;
        start     = 0;
        rank      = 0;
        best_rank = NUM_CH;
        if (MODE == 0) begin
            start = int'(ptr_q);
        end else begin
            start = 0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            rank = i - start;
            if (rank < 0) begin
                rank = rank + NUM_CH;
            end else begin
                rank = rank;
            end
            if (in_valid[i] && (rank < best_rank)) begin
                best_rank = rank;
                winner_s  = CH_W'(i);
                found_s   = 1'b1;
            end else begin
                best_rank = best_rank;
            end
        end
    end

    // Data select and one-hot grant for the winning channel.
    always_comb begin
        win_data_s = '0;
        in_ready_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (CH_W'(i) == winner_s) begin
                win_data_s    = in_data[i*WIDTH +: WIDTH];
                in_ready_s[i] = load_s && found_s;
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    // Next state of the output register and the round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (load_s) begin
            if (found_s) begin
                out_valid_d = 1'b1;
                out_data_d  = win_data_s;
                out_ch_d    = winner_s;
                if (MODE != 0) begin
                    ptr_d = '0;
                end else if (int'(winner_s) == (NUM_CH - 1)) begin
                    // Explicit wrap keeps ptr below NUM_CH for non-power-of-two sizes.
                    ptr_d = '0;
                end else begin
                    ptr_d = winner_s + CH_W'(1);
                end
            end else begin
                // Idle: drop valid but keep the last word and channel visible.
                out_valid_d = 1'b0;
            end
        end else begin
            // Stalled downstream: everything holds.
            out_valid_d = out_valid_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: three instances (NUM_CH=4 round-robin, NUM_CH=4
// fixed priority, NUM_CH=3 round-robin) each driven by its own stimulus
// process. Expected grants come from a behavioural arbiter model and are
// queued; a per-instance monitor pops and compares on every output transfer.
module tb_rr_arb_mux;

    logic clk = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int N = (g == 2) ? 3 : 4;
        localparam int M = (g == 1) ? 1 : 0;

        typedef struct packed {
            logic [1:0]  ch;
            logic [31:0] data;
        } exp_t;

        logic          rst;
        logic [N-1:0]  in_valid;
        logic [N*32-1:0] in_data;
        logic [N-1:0]  in_ready;
        logic          out_valid;
        logic [31:0]   out_data;
        logic [1:0]    out_ch;
        logic          out_ready;

        exp_t          exp_q[$];
        int            mptr;
        bit            mv;
        bit            done;
        logic [31:0]   last_data = '0;
        logic [1:0]    last_ch = '0;

        rr_arb_mux #(.WIDTH(32), .NUM_CH(N), .MODE(M)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_data   (in_data),
            .in_ready  (in_ready),
            .out_valid (out_valid),
            .out_data  (out_data),
            .out_ch    (out_ch),
            .out_ready (out_ready)
        );

        // Reference arbiter: first valid index when walking from p upward, wrapping.
        function automatic int pick(logic [N-1:0] v, int p);
            for (int k = 0; k < N; k++) begin
                if (v[(p + k) % N]) return (p + k) % N;
            end
            return -1;
        endfunction

        // One cycle: raise requests, set out_ready, check the grant, queue the
        // expected output word, then advance the model across the clock edge.
        task automatic step(input logic [N-1:0] raise, input bit fixed,
                            input logic [31:0] base, input bit rdy,
                            output logic [N-1:0] seen);
            int w;
            bit ld;
            exp_t e;
            for (int i = 0; i < N; i++) begin
                if (raise[i] && !in_valid[i]) begin
                    in_valid[i] = 1'b1;
                    in_data[i*32 +: 32] = fixed ? base + 32'(i) : $urandom();
                end
            end
            out_ready = rdy;
            @(negedge clk);
            ld = !mv || rdy;
            w = ld ? pick(in_valid, (M == 0) ? mptr : 0) : -1;
            seen = in_ready;
            check($sformatf("dut%0d in_ready", g), 64'(in_ready),
                  (w >= 0) ? (64'd1 << w) : 64'd0);
            if (w >= 0) begin
                e.ch   = 2'(w);
                e.data = in_data[w*32 +: 32];
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
            if (ld) mv = (w >= 0);
            if (w >= 0) begin
                in_valid[w] = 1'b0;
                if (M == 0) mptr = (w + 1) % N;
            end
        endtask

        // Monitor: compare the presented word against the oldest expectation.
        initial begin : mon
            exp_t e;
            forever begin
                @(negedge clk);
                if (!rst && out_valid) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("dut%0d unexpected out_valid", g), 64'(out_valid), 64'd0);
                    end else begin
                        e = out_ready ? exp_q.pop_front() : exp_q[0];
                        check($sformatf("dut%0d out_ch", g), 64'(out_ch), 64'(e.ch));
                        check($sformatf("dut%0d out_data", g), 64'(out_data), 64'(e.data));
                        if (out_ready) begin
                            last_data = e.data;
                            last_ch   = e.ch;
                        end
                    end
                end
            end
        end

        initial begin : drv
            logic [N-1:0] seen;
            rst = 1'b1;
            in_valid = '0;
            in_data = '0;
            out_ready = 1'b0;
            mptr = 0;
            mv = 1'b0;
            done = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("dut%0d reset out_valid", g), 64'(out_valid), 64'd0);
            check($sformatf("dut%0d reset out_data", g), 64'(out_data), 64'd0);
            check($sformatf("dut%0d reset out_ch", g), 64'(out_ch), 64'd0);
            rst = 1'b0;

            // All channels requesting with out_ready held high.
            for (int k = 0; k < 2 * N; k++) begin
                step('1, 1'b1, 32'h1000_0000, 1'b1, seen);
                check($sformatf("dut%0d sweep grant %0d", g, k), 64'(seen),
                      (M == 0) ? (64'd1 << (k % N)) : 64'd1);
            end

            // Random requests and backpressure.
            for (int k = 0; k < 300; k++) begin
                step(N'($urandom_range(0, (1 << N) - 1)), 1'b0, 32'h0,
                     ($urandom_range(0, 3) != 0), seen);
            end

            // Drain, then idle: valid must drop while data and channel hold.
            for (int k = 0; k < N + 2; k++) begin
                step('0, 1'b0, 32'h0, 1'b1, seen);
            end
            check($sformatf("dut%0d idle out_valid", g), 64'(out_valid), 64'd0);
            check($sformatf("dut%0d idle out_data hold", g), 64'(out_data), 64'(last_data));
            check($sformatf("dut%0d idle out_ch hold", g), 64'(out_ch), 64'(last_ch));
            check($sformatf("dut%0d queue drained", g), 64'(exp_q.size()), 64'd0);

            // Load DEADBEEF from channel 1, stall it, then reset without a clock edge.
            step(N'(2), 1'b1, 32'hDEAD_BEEE, 1'b1, seen);
            out_ready = 1'b0;
            check($sformatf("dut%0d pre-reset out_data", g), 64'(out_data), 64'hDEAD_BEEF);
            rst = 1'b1;
            #1;
            check($sformatf("dut%0d async reset out_valid", g), 64'(out_valid), 64'd0);
            check($sformatf("dut%0d async reset out_data", g), 64'(out_data), 64'd0);
            check($sformatf("dut%0d async reset out_ch", g), 64'(out_ch), 64'd0);
            exp_q.delete();
            mv = 1'b0;
            mptr = 0;
            in_valid = '0;
            @(posedge clk);
            #1;
            rst = 1'b0;

            // First grant after reset must start searching at channel 0.
            step('1, 1'b1, 32'h2000_0000, 1'b1, seen);
            check($sformatf("dut%0d post-reset first grant", g), 64'(seen), 64'd1);
            for (int k = 0; k < N + 2; k++) begin
                step('0, 1'b0, 32'h0, 1'b1, seen);
            end
            check($sformatf("dut%0d final queue drained", g), 64'(exp_q.size()), 64'd0);
            done = 1'b1;
        end
    end

    initial begin : summary
        bit all_done;
        all_done = 1'b0;
        for (int c = 0; c < 20000 && !all_done; c++) begin
            @(posedge clk);
            all_done = gen_dut[0].done && gen_dut[1].done && gen_dut[2].done;
        end
        if (!all_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: stimulus did not complete, got not-done expected done");
        end
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
